// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, widths and the processor NoC-write opcode.
package noc_pkg;

  localparam int FLIT_W      = 16;
  localparam int PKT_W       = 12;
  localparam int NODE_ID_W   = 4;

  localparam int SRC_MSB     = 15;
  localparam int SRC_LSB     = 12;
  localparam int DEST_MSB    = 11;
  localparam int DEST_LSB    = 8;
  localparam int PAYLOAD_MSB = 7;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [5:0] NOC_WRITE_OPCODE = 6'b110000;

  typedef struct packed {
    logic [NODE_ID_W-1:0] src;
    logic [NODE_ID_W-1:0] dest;
    logic [7:0]           payload;
  } noc_flit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only when a pop
// happens on the same edge, so the freed slot is reused immediately.
module noc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = pop_req && !empty;
  assign push  = push_req && (!full || pop);

  // Head is masked to zero while empty so nothing stale leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; entries are not reset, the empty mask hides them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_inject_ni.sv
// NoC injection network interface: stamps the local source ID on each
// processor NoC write, buffers it and injects flits over valid/ready.
// The processor cannot stall, so writes arriving while full are dropped
// and counted.
module noc_inject_ni
  import noc_pkg::*;
#(
  parameter int                   DEPTH  = 4,
  parameter logic [NODE_ID_W-1:0] SRC_ID = 4'h0,
  parameter int                   CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              noc_write_i,
  input  logic [31:0]       cpu_data_i,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [FLIT_W-1:0] tx_flit_o,
  output logic              fifo_full_o,
  output logic              fifo_empty_o,
  output logic [CNT_W-1:0]  fifo_count_o,
  output logic [7:0]        drop_count_o,
  output logic              overflow_o
);

  noc_flit_t in_flit;
  logic      pop;
  logic      drop;
  logic      unused_hi;

  // Only the low packet bits carry meaning; the rest of the bus is ignored.
  assign unused_hi = ^cpu_data_i[31:PKT_W];

  assign in_flit.src     = SRC_ID;
  assign in_flit.dest    = cpu_data_i[DEST_MSB:DEST_LSB];
  assign in_flit.payload = cpu_data_i[PAYLOAD_MSB:PAYLOAD_LSB];

  assign tx_valid_o = !fifo_empty_o;
  assign pop        = tx_valid_o && tx_ready_i;
  assign drop       = noc_write_i && fifo_full_o && !pop;

  noc_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (noc_write_i),
    .pop_req  (pop),
    .wr_data  (in_flit),
    .rd_data  (tx_flit_o),
    .count    (fifo_count_o),
    .full     (fifo_full_o),
    .empty    (fifo_empty_o)
  );

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count_o <= '0;
      overflow_o   <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_noc_inject_ni.sv
// Directed bench for noc_inject_ni (DEPTH=4, SRC_ID=3). Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_noc_inject_ni;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             noc_write_i;
  logic [31:0]      cpu_data_i;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic [15:0]      tx_flit_o;
  logic             fifo_full_o;
  logic             fifo_empty_o;
  logic [CNT_W-1:0] fifo_count_o;
  logic [7:0]       drop_count_o;
  logic             overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  noc_inject_ni #(.DEPTH(DEPTH), .SRC_ID(4'h3), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .noc_write_i  (noc_write_i),
    .cpu_data_i   (cpu_data_i),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_flit_o    (tx_flit_o),
    .fifo_full_o  (fifo_full_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_count_o (fifo_count_o),
    .drop_count_o (drop_count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle write pulse; returns at the next falling edge.
  task automatic do_write(input logic [31:0] d);
    noc_write_i = 1'b1;
    cpu_data_i  = d;
    @(negedge clk);
    noc_write_i = 1'b0;
  endtask

  logic [15:0] exp3 [4] = '{16'h3101, 16'h3202, 16'h3303, 16'h3404};
  logic [15:0] exp4 [4] = '{16'h3022, 16'h3033, 16'h3044, 16'h3666};

  initial begin
    rst_n = 1'b0; noc_write_i = 1'b1; cpu_data_i = 32'h0000_0ABC; tx_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_empty", 32'(fifo_empty_o), 32'd1);
    chk("rst_full",  32'(fifo_full_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_flit",  32'(tx_flit_o), 32'd0);
    chk("rst_drop",  32'(drop_count_o), 32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    rst_n = 1'b1; noc_write_i = 1'b0;
    @(negedge clk);

    // 1: single write, one-cycle latency, popped immediately
    tx_ready_i = 1'b1;
    do_write(32'h0000_0A5C);
    chk("t1_valid", 32'(tx_valid_o), 32'd1);
    chk("t1_flit",  32'(tx_flit_o), 32'h3A5C);
    @(negedge clk);
    chk("t1_empty", 32'(fifo_empty_o), 32'd1);
    chk("t1_valid0", 32'(tx_valid_o), 32'd0);

    // 2: upper bus bits ignored
    do_write(32'hFFFF_F123);
    chk("t2_flit", 32'(tx_flit_o), 32'h3123);
    chk("t2_drop", 32'(drop_count_o), 32'd0);
    @(negedge clk);

    // 3: fill, drop on full, drain in order
    tx_ready_i = 1'b0;
    do_write(32'h101); do_write(32'h202); do_write(32'h303); do_write(32'h404);
    chk("t3_full",  32'(fifo_full_o), 32'd1);
    chk("t3_count", 32'(fifo_count_o), 32'd4);
    do_write(32'h505);
    chk("t3_drop",  32'(drop_count_o), 32'd1);
    chk("t3_ovf",   32'(overflow_o), 32'd1);
    chk("t3_count2", 32'(fifo_count_o), 32'd4);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", 32'(tx_valid_o), 32'd1);
      chk("t3_flit",  32'(tx_flit_o), 32'(exp3[i]));
      @(negedge clk);
    end
    chk("t3_empty", 32'(fifo_empty_o), 32'd1);

    // 4: push while full with a simultaneous pop is accepted
    tx_ready_i = 1'b0;
    do_write(32'h011); do_write(32'h022); do_write(32'h033); do_write(32'h044);
    tx_ready_i = 1'b1;
    do_write(32'h666);
    tx_ready_i = 1'b0;
    chk("t4_count", 32'(fifo_count_o), 32'd4);
    chk("t4_drop",  32'(drop_count_o), 32'd1);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_flit", 32'(tx_flit_o), 32'(exp4[i]));
      @(negedge clk);
    end
    chk("t4_empty", 32'(fifo_empty_o), 32'd1);

    // 5: flit held stable under backpressure
    tx_ready_i = 1'b0;
    do_write(32'h777);
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", 32'(tx_valid_o), 32'd1);
      chk("t5_flit",  32'(tx_flit_o), 32'h3777);
      @(negedge clk);
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_empty", 32'(fifo_empty_o), 32'd1);

    // 6: reset mid-operation clears everything and ignores the write
    tx_ready_i = 1'b0;
    do_write(32'h0A1); do_write(32'h0A2); do_write(32'h0A3); do_write(32'h0A4);
    do_write(32'h0A5);
    chk("t6_drop2", 32'(drop_count_o), 32'd2);
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
    chk("t6_count3", 32'(fifo_count_o), 32'd3);
    rst_n = 1'b0; noc_write_i = 1'b1; cpu_data_i = 32'h999;
    @(negedge clk);
    rst_n = 1'b1; noc_write_i = 1'b0;
    chk("t6_count", 32'(fifo_count_o), 32'd0);
    chk("t6_valid", 32'(tx_valid_o), 32'd0);
    chk("t6_flit",  32'(tx_flit_o), 32'd0);
    chk("t6_drop",  32'(drop_count_o), 32'd0);
    chk("t6_ovf",   32'(overflow_o), 32'd0);
    @(negedge clk);
    chk("t6_nocap", 32'(fifo_empty_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
